cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Sits directly downstream of the execution units. Collects completed results from N_EXU units over their exu2cdb_itf links (cdb modport side).
- Broadcasts exactly one result per cycle on the common data bus (cdb_itf, mst side). The bus is consumed by reservation stations, the register file unit and the ROB.
- Each unit has a one-entry holding buffer, so a unit can hand off a result even when it loses arbitration. A round-robin arbiter gives fair access to the bus.

Parameters:
- N_EXU, 4, number of execution units / request ports (2..8).
- TAG_W, 4, tag width; must match the dec2rvs/exu2cdb/cdb interface parameter.

Ports:
- clk  in  1  core clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- exu_req  in  N_EXU  per-unit result valid (exu2cdb req).
- exu_rdy  out  N_EXU  per-unit buffer can accept (exu2cdb rdy).
- exu_tag  in  N_EXU*TAG_W  per-unit result tag; unit i occupies bits [i*TAG_W +: TAG_W].
- exu_wdata  in  N_EXU*32  per-unit result data; unit i occupies bits [i*32 +: 32].
- cdb_wr  out  1  broadcast valid (cdb wr).
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_wdata  out  32  broadcast data.

Behaviour:
- Reset (asynchronous, rst=1):
  - vld_q[i]=0 for all i; ptr=0.
  - cdb_wr=0, cdb_tag=0, cdb_wdata=0.
  - exu_rdy is combinational and evaluates to all-ones during reset and the cycle after.
  - Asserting rst mid-operation discards all buffered results without broadcasting them.
- Per-port buffer i holds vld_q[i], tag_q[i], data_q[i].
- exu_rdy[i] = ~vld_q[i] | gnt[i]. It is combinational and does not depend on exu_req.
- Accept: when exu_req[i] & exu_rdy[i], the buffer loads exu_tag/exu_wdata and sets vld_q[i]=1 on the next edge.
- Release: when gnt[i] and there is no accept, vld_q[i] clears.
- Simultaneous grant and accept on the same port: the buffer reloads with the new result and vld_q stays 1. This allows back-to-back results from one port.
- A unit holding exu_req=1 while exu_rdy=0 must keep its tag/data stable. The arbiter does not sample it until exu_rdy=1.
- Arbitration (combinational, in cdb_rr_arb):
  - Input is vld_q. The search scans indices ptr, ptr+1, … modulo N_EXU.
  - gnt is one-hot with the first valid index found, or zero if none is valid.
  - On any grant, ptr <= (granted index + 1) mod N_EXU. With no grant, ptr holds.
  - The wrap from N_EXU-1 goes to 0.
- Output stage (registered):
  - cdb_wr <= |vld_q.
  - cdb_tag/cdb_wdata <= tag_q/data_q of the granted port.
  - When there is no grant: cdb_wr <= 0 and tag/wdata hold their previous values (don't-care to consumers).
- Latency: accept at edge t gives buffer valid from t; the earliest broadcast is cdb_wr=1 in the cycle after edge t+1, i.e. 2 cycles from handshake to bus.
- Throughput: 1 broadcast per cycle total. Each accepted result is broadcast exactly once (cdb_wr is a one-cycle pulse per result) and no result is ever dropped.
- Starvation bound: a valid buffer is granted within N_EXU cycles.
- Tag values carry no special meaning. The arbiter never inspects or compares tags.

Decomposition:
- Shared core package:
  - TAG_W default and N_EXU default.
  - A typedef for the cdb payload struct {tag, wdata}, shared with the ROB and reservation stations.
- Sub-module cdb_rr_arb (parameter N):
  - Inputs: clk, rst, req[N].
  - Outputs: gnt[N] one-hot and gnt_idx.
  - Owns the ptr register; its reset matches the top level.
- The top-level core binds exu2cdb_itf.cdb and cdb_itf.mst modports onto the flat ports.

Test Plan:
- Single result: reset, then exu_req[2]=1, tag=4'h5, wdata=32'hDEADBEEF for one cycle.
  - Required: exu_rdy[2]=1 at handshake; cdb_wr=1, cdb_tag=5, cdb_wdata=DEADBEEF exactly 2 cycles after the handshake, for one cycle only.
- Simultaneous requests: all 4 ports request in one cycle with tags 1,2,3,4.
  - Required: broadcasts on 4 consecutive cycles in order 1,2,3,4 (ptr=0).
  - During this, exu_rdy[i] is 0 for each still-waiting port and rises in the cycle that port is granted.
- Back-to-back on one port: port 1 streams tags 6,7,8 on consecutive cycles with no other traffic.
  - Required: exu_rdy[1] stays 1 throughout; cdb shows 6,7,8 on consecutive cycles with no bubbles.
- Fairness and wrap: ports 0 and 3 both request continuously.
  - Required: cdb alternates 3,0,3,0… after the first grant, and no port waits more than N_EXU cycles.
- Back-pressure: a port is blocked (exu_rdy=0) while holding req and changing data.
  - Required: only data present in the cycle exu_rdy=1 is broadcast, and no duplicate appears.
- Reset mid-flight: with 3 buffers valid, assert rst asynchronously mid-cycle.
  - Required: cdb_wr=0 immediately; after release, no stale tag is ever broadcast and ptr restarts at 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared core definitions for the common data bus: default widths and the
// broadcast payload seen by the ROB, reservation stations and register file.
package cdb_arbiter_pkg;

   localparam int N_EXU_DEF  = 4;
   localparam int TAG_W_DEF  = 4;
   localparam int CDB_DATA_W = 32;

   typedef struct packed {
      logic [TAG_W_DEF-1:0]  tag;
      logic [CDB_DATA_W-1:0] wdata;
   } cdb_payload_t;

endpackage

// File: rtl/cdb_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, then moves
// ptr just past the winner so every requester is served within N cycles.
module cdb_rr_arb #(
   parameter int N = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] scan_idx;
   logic             found;

   // Modular add for off in [0, N]; a single subtraction suffices.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
      int unsigned s;
      s = int'(unsigned'(base)) + off;
      if (s >= N) s = s - N;
      return IDX_W'(s);
   endfunction

   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < N; k++) begin
         scan_idx = wrap_add(ptr, k);
         if (!found && req[scan_idx]) begin
            found          = 1'b1;
            gnt[scan_idx]  = 1'b1;
            gnt_idx        = scan_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= wrap_add(gnt_idx, 1);
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects execution-unit results into one-entry buffers and broadcasts one
// result per cycle on the common data bus under round-robin arbitration.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_EXU = N_EXU_DEF,
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_EXU-1:0]            exu_req,
   output logic [N_EXU-1:0]            exu_rdy,
   input  logic [N_EXU*TAG_W-1:0]      exu_tag,
   input  logic [N_EXU*CDB_DATA_W-1:0] exu_wdata,
   output logic                        cdb_wr,
   output logic [TAG_W-1:0]            cdb_tag,
   output logic [CDB_DATA_W-1:0]       cdb_wdata
);

   localparam int IDX_W = (N_EXU > 1) ? $clog2(N_EXU) : 1;

   logic [N_EXU-1:0]      vld_q;
   logic [TAG_W-1:0]      tag_q  [N_EXU];
   logic [CDB_DATA_W-1:0] data_q [N_EXU];

   logic [N_EXU-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic [N_EXU-1:0] accept;

   cdb_rr_arb #(
      .N (N_EXU)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (vld_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // A granted buffer empties this edge, so it may take a new result at once.
   assign exu_rdy = ~vld_q | gnt;
   assign accept  = exu_req & exu_rdy;

   // Buffer stage: valid bits are control and reset; payload is not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= (vld_q & ~gnt) | accept;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_EXU; i++) begin
         if (accept[i]) begin
            tag_q[i]  <= exu_tag[i*TAG_W +: TAG_W];
            data_q[i] <= exu_wdata[i*CDB_DATA_W +: CDB_DATA_W];
         end
      end
   end

   // Broadcast stage: payload holds its last value when the bus is idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_wr    <= 1'b0;
         cdb_tag   <= '0;
         cdb_wdata <= '0;
      end else begin
         cdb_wr <= |vld_q;
         if (|vld_q) begin
            cdb_tag   <= tag_q[gnt_idx];
            cdb_wdata <= data_q[gnt_idx];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a behavioural model
// of per-port buffers and a round-robin scan, plus a broadcast scoreboard.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    exu_req;
   logic [N-1:0]    exu_rdy;
   logic [N*TW-1:0] exu_tag;
   logic [N*32-1:0] exu_wdata;
   logic            cdb_wr;
   logic [TW-1:0]   cdb_tag;
   logic [31:0]     cdb_wdata;

   cdb_arbiter #(.N_EXU(N), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .exu_req   (exu_req),
      .exu_rdy   (exu_rdy),
      .exu_tag   (exu_tag),
      .exu_wdata (exu_wdata),
      .cdb_wr    (cdb_wr),
      .cdb_tag   (cdb_tag),
      .cdb_wdata (cdb_wdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: buffer contents, rotating priority start, next bus value.
   bit          m_vld  [N];
   logic [TW-1:0] m_tag [N];
   logic [31:0] m_data [N];
   int          m_ptr;
   bit          e_wr;
   logic [TW-1:0] e_tag;
   logic [31:0] e_data;

   int pend [logic [31:0]];
   int cyc  = 0;
   logic [31:0] uniq = 32'h1000_0000;

   function automatic int model_grant();
      for (int k = 0; k < N; k++)
         if (m_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_vld[i] = 0;
      m_ptr  = 0;
      e_wr   = 0;
      e_tag  = '0;
      e_data = '0;
      pend.delete();
   endtask

   // Called at a falling edge: check, drive, advance model, cross one cycle.
   task automatic step(input logic [N-1:0] req, input logic [N*TW-1:0] tags,
                       input logic [N*32-1:0] datas);
      int g;
      int lat;
      logic [N-1:0] rdy_exp;
      chk("cdb_wr", cdb_wr, e_wr);
      if (e_wr) begin
         chk("cdb_tag", cdb_tag, e_tag);
         chk("cdb_wdata", cdb_wdata, e_data);
      end
      if (cdb_wr === 1'b1) begin
         chk("sb_known", pend.exists(cdb_wdata), 1);
         if (pend.exists(cdb_wdata)) begin
            lat = cyc - pend[cdb_wdata];
            chk("sb_latency", (lat >= 2 && lat <= N + 1), 1);
            pend.delete(cdb_wdata);
         end
      end
      g = model_grant();
      for (int i = 0; i < N; i++) rdy_exp[i] = !m_vld[i] || (i == g);
      chk("exu_rdy", exu_rdy, rdy_exp);

      exu_req   = req;
      exu_tag   = tags;
      exu_wdata = datas;

      e_wr = (g >= 0);
      if (g >= 0) begin
         e_tag    = m_tag[g];
         e_data   = m_data[g];
         m_ptr    = (g + 1) % N;
         m_vld[g] = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (req[i] && rdy_exp[i]) begin
            m_vld[i]  = 1;
            m_tag[i]  = tags[i*TW +: TW];
            m_data[i] = datas[i*32 +: 32];
            pend[datas[i*32 +: 32]] = cyc;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic fresh_data(output logic [N*32-1:0] d);
      for (int i = 0; i < N; i++) begin
         d[i*32 +: 32] = uniq;
         uniq++;
      end
   endtask

   task automatic idle(input int n);
      logic [N*32-1:0] d;
      for (int k = 0; k < n; k++) begin
         fresh_data(d);
         step('0, '0, d);
      end
   endtask

   initial begin
      logic [N*32-1:0] d;
      logic [N*TW-1:0] t;
      rst = 1'b1;
      exu_req = '0;
      exu_tag = '0;
      exu_wdata = '0;
      model_reset();
      #3;
      chk("rst_rdy", exu_rdy, {N{1'b1}});
      chk("rst_wr", cdb_wr, 0);
      chk("rst_tag", cdb_tag, 0);
      chk("rst_wdata", cdb_wdata, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single result on port 2.
      fresh_data(d);
      d[2*32 +: 32] = 32'hDEADBEEF;
      t = '0;
      t[2*TW +: TW] = 4'h5;
      step(4'b0100, t, d);
      idle(1);
      chk("single_wr", cdb_wr, 1);
      chk("single_tag", cdb_tag, 4'h5);
      chk("single_wdata", cdb_wdata, 32'hDEADBEEF);
      idle(2);

      // All ports at once, tags 1..4 (ptr sits at 3 after port 2; reset first).
      rst = 1'b1;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      fresh_data(d);
      step(4'b1111, {4'h4, 4'h3, 4'h2, 4'h1}, d);
      idle(6);

      // Back-to-back on port 1.
      for (int k = 0; k < 3; k++) begin
         fresh_data(d);
         t = '0;
         t[1*TW +: TW] = TW'(6 + k);
         step(4'b0010, t, d);
      end
      idle(4);

      // Ports 0 and 3 continuously.
      for (int k = 0; k < 12; k++) begin
         fresh_data(d);
         step(4'b1001, {4'h3, 4'h0, 4'h0, 4'h0}, d);
      end
      idle(4);

      // Randomized traffic, data changes freely while blocked.
      for (int k = 0; k < 400; k++) begin
         fresh_data(d);
         for (int i = 0; i < N; i++) t[i*TW +: TW] = TW'($urandom);
         step(N'($urandom & $urandom), t, d);
      end
      idle(N + 3);
      chk("drained", pend.num(), 0);

      // Asynchronous reset with three buffers still holding results.
      fresh_data(d);
      step(4'b1111, {4'hA, 4'hB, 4'hC, 4'hD}, d);
      idle(1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_wr", cdb_wr, 0);
      chk("mid_rst_rdy", exu_rdy, {N{1'b1}});
      exu_req = '0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle(N + 2);
      fresh_data(d);
      step(4'b1111, {4'h1, 4'h2, 4'h3, 4'h4}, d);
      idle(N + 3);
      chk("drained_end", pend.num(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
